// File: rtl/score_keeper_if.sv
// Bundles the match-scorer inputs (tick, max_score, start, point pulses)
// and its registered outputs (scores, target, play_en, winner, state).
// master: the side that drives the inputs and reads the results.
// slave:  the score_keeper itself.
interface score_keeper_if #(
  parameter int SCORE_W = 5
);
  logic               tick;
  logic [SCORE_W-1:0] max_score;
  logic               start;
  logic               p1_point;
  logic               p2_point;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [SCORE_W-1:0] target;
  logic               play_en;
  logic [1:0]         winner;
  logic [1:0]         state;

  modport master (
    output tick, max_score, start, p1_point, p2_point,
    input  score1, score2, target, play_en, winner, state
  );

  modport slave (
    input  tick, max_score, start, p1_point, p2_point,
    output score1, score2, target, play_en, winner, state
  );
endinterface

// File: rtl/score_keeper.sv
// Match scorer. Latches the winning score at match start, counts points for
// both players, pauses for a serve after every point and declares a winner.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    score_keeper_if.slave: tick, max_score, start, p1_point, p2_point in;
//          score1, score2, target, play_en, winner, state out (all registered)
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for a start press; target latched on exit
// PLAY  | ball live; point pulses update the scores
// SERVE | pause after a point; counts SERVE_TICKS ticks
// OVER  | a player reached target; start press returns to IDLE
module score_keeper #(
  parameter int SCORE_W     = 5,
  parameter int SERVE_TICKS = 3
) (
  input logic           clk,
  input logic           rst_n,
  score_keeper_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_SERVE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam int              CNT_W      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);

  logic [1:0]         state_q,  state_nxt;
  logic [SCORE_W-1:0] score1_q, score1_nxt;
  logic [SCORE_W-1:0] score2_q, score2_nxt;
  logic [SCORE_W-1:0] target_q, target_nxt;
  logic [1:0]         winner_q, winner_nxt;
  logic [CNT_W-1:0]   cnt_q,    cnt_nxt;
  logic               play_en_q;
  logic               start_q;
  logic               start_rise;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  assign start_rise = bus.start & ~start_q;
  assign s1_inc     = score1_q + SCORE_W'(1);
  assign s2_inc     = score2_q + SCORE_W'(1);

  always_comb begin
    state_nxt  = state_q;
    score1_nxt = score1_q;
    score2_nxt = score2_q;
    target_nxt = target_q;
    winner_nxt = winner_q;
    cnt_nxt    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          // A zero target would make the match unwinnable; treat it as 1.
          target_nxt = (bus.max_score == '0) ? SCORE_W'(1) : bus.max_score;
          score1_nxt = '0;
          score2_nxt = '0;
          winner_nxt = 2'b00;
          state_nxt  = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (bus.p1_point && bus.p2_point) begin
          state_nxt = ST_SERVE;
          cnt_nxt   = SERVE_LOAD;
        end else if (bus.p1_point) begin
          score1_nxt = s1_inc;
          if (s1_inc == target_q) begin
            state_nxt  = ST_OVER;
            winner_nxt = 2'b01;
          end else begin
            state_nxt = ST_SERVE;
            cnt_nxt   = SERVE_LOAD;
          end
        end else if (bus.p2_point) begin
          score2_nxt = s2_inc;
          if (s2_inc == target_q) begin
            state_nxt  = ST_OVER;
            winner_nxt = 2'b10;
          end else begin
            state_nxt = ST_SERVE;
            cnt_nxt   = SERVE_LOAD;
          end
        end
      end

      ST_SERVE: begin
        if (bus.tick) begin
          if (cnt_q == '0) begin
            state_nxt = ST_PLAY;
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_OVER: begin
        // Target is kept so the display still shows the last match's goal.
        if (start_rise) begin
          score1_nxt = '0;
          score2_nxt = '0;
          winner_nxt = 2'b00;
          state_nxt  = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      score1_q  <= '0;
      score2_q  <= '0;
      target_q  <= '0;
      winner_q  <= 2'b00;
      cnt_q     <= '0;
      play_en_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      score1_q  <= score1_nxt;
      score2_q  <= score2_nxt;
      target_q  <= target_nxt;
      winner_q  <= winner_nxt;
      cnt_q     <= cnt_nxt;
      // Decoded from the next state so it lines up with the state register.
      play_en_q <= (state_nxt == ST_PLAY);
      start_q   <= bus.start;
    end
  end

  assign bus.state   = state_q;
  assign bus.score1  = score1_q;
  assign bus.score2  = score2_q;
  assign bus.target  = target_q;
  assign bus.winner  = winner_q;
  assign bus.play_en = play_en_q;

endmodule
